// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector gather/scatter controller.
// Holds the controller state encoding, the default parameter values, the packet
// typedefs describing vector (CPU-side) and scalar (memory-side) transfers at the
// default widths, and a small index-width helper.
package vec_mem_pkg;

  localparam int unsigned DefNumLanes      = 8;
  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefDataW         = 64;
  localparam int unsigned DefSrcW          = 16;
  localparam int unsigned DefMaxOutstanding = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StRespond
  } gs_state_e;

  // Scalar memory request as seen on the mem_req_* bus.
  typedef struct packed {
    logic                write;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
    logic [DefSrcW-1:0]  source;
  } mem_req_pkt_t;

  // Scalar memory read response.
  typedef struct packed {
    logic [DefDataW-1:0] data;
    logic [DefSrcW-1:0]  source;
  } mem_rsp_pkt_t;

  // Vector request as seen on the cpu_req_* bus.
  typedef struct packed {
    logic                            write;
    logic [DefNumLanes-1:0]          mask;
    logic [DefNumLanes*DefAddrW-1:0] addr;
    logic [DefNumLanes*DefDataW-1:0] wdata;
    logic [DefSrcW-1:0]              source;
  } vec_req_pkt_t;

  // Vector response as seen on the cpu_rsp_* bus.
  typedef struct packed {
    logic                            write;
    logic [DefNumLanes*DefDataW-1:0] rdata;
    logic [DefSrcW-1:0]              source;
    logic                            error;
  } vec_rsp_pkt_t;

  // Width of an index into n items; never zero so single-item configs still elaborate.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_index_fifo.sv
// Lane-index FIFO: remembers which lane each in-flight read belongs to, so the
// in-order memory responses can be steered back into the right rdata lane.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i  enqueue one lane index
//   pop_i            dequeue the head entry
//   head_o           lane index at the head
// The owner guarantees no push when full and no pop when empty.
module lane_index_fifo
  import vec_mem_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o
);

  localparam int unsigned     PtrW    = idx_w(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/vector_gather_scatter_ctrl.sv
// Vector gather/scatter controller.
// Accepts one vector request (per-lane address/data plus an active-lane mask),
// issues one scalar memory access per active lane in ascending lane order,
// collects in-order read responses into the lane they belong to, and returns a
// single vector response.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   cpu_req_*             vector request (valid/ready handshake)
//   cpu_rsp_*             vector response (valid/ready handshake, held stable)
//   mem_req_*             scalar memory request (valid/ready handshake)
//   mem_rsp_*             scalar in-order read responses, always accepted
module vector_gather_scatter_ctrl
  import vec_mem_pkg::*;
#(
  parameter int unsigned NUM_LANES       = DefNumLanes,
  parameter int unsigned ADDR_W          = DefAddrW,
  parameter int unsigned DATA_W          = DefDataW,
  parameter int unsigned SRC_W           = DefSrcW,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  // CPU request
  input  logic                        cpu_req_valid_i,
  output logic                        cpu_req_ready_o,
  input  logic                        cpu_req_write_i,
  input  logic [NUM_LANES-1:0]        cpu_req_mask_i,
  input  logic [NUM_LANES*ADDR_W-1:0] cpu_req_addr_i,
  input  logic [NUM_LANES*DATA_W-1:0] cpu_req_wdata_i,
  input  logic [SRC_W-1:0]            cpu_req_source_i,
  // CPU response
  output logic                        cpu_rsp_valid_o,
  input  logic                        cpu_rsp_ready_i,
  output logic                        cpu_rsp_write_o,
  output logic [NUM_LANES*DATA_W-1:0] cpu_rsp_rdata_o,
  output logic [SRC_W-1:0]            cpu_rsp_source_o,
  output logic                        cpu_rsp_error_o,
  // Memory request
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic                        mem_req_write_o,
  output logic [ADDR_W-1:0]           mem_req_addr_o,
  output logic [DATA_W-1:0]           mem_req_wdata_o,
  output logic [SRC_W-1:0]            mem_req_source_o,
  // Memory response
  input  logic                        mem_rsp_valid_i,
  input  logic [DATA_W-1:0]           mem_rsp_data_i,
  input  logic [SRC_W-1:0]            mem_rsp_source_i
);

  localparam int unsigned     LaneW  = idx_w(NUM_LANES);
  localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);

  gs_state_e                 state_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      write_q;
  logic [NUM_LANES-1:0]      mask_q;
  logic [NUM_LANES*ADDR_W-1:0] addr_q;
  logic [NUM_LANES*DATA_W-1:0] wdata_q;
  logic [SRC_W-1:0]          source_q;
  logic [NUM_LANES*DATA_W-1:0] rdata_q;
  logic                      error_q;
  logic [NUM_LANES-1:0]      issued_q;
  logic [CntW-1:0]           outstanding_q;
  logic [CntW-1:0]           outstanding_d;

  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] sel_onehot;
  logic [NUM_LANES-1:0] rest;
  logic [LaneW-1:0]     lane_sel;
  logic [LaneW-1:0]     fifo_head;
  logic                 accept;
  logic                 can_issue;
  logic                 mem_fire;
  logic                 rd_issue;
  logic                 rsp_take;
  logic                 last_issue;
  logic                 rsp_done;

  // Lanes still owed a memory access; the lowest one goes out first.
  assign pending    = mask_q & ~issued_q;
  assign sel_onehot = pending & ~(pending - NUM_LANES'(1));
  assign rest       = pending & (pending - NUM_LANES'(1));
  assign last_issue = (rest == '0);

  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (sel_onehot[i]) begin
        lane_sel = LaneW'(i);
      end
    end
  end

  // Writes are fire-and-forget, so only reads are throttled by the in-flight cap.
  assign can_issue       = write_q || (outstanding_q != MaxOut);
  assign mem_req_valid_o = (state_q == StIssue) && (|pending) && can_issue;
  assign mem_req_write_o = write_q;
  assign mem_req_addr_o  = addr_q[lane_sel*ADDR_W +: ADDR_W];
  assign mem_req_wdata_o = wdata_q[lane_sel*DATA_W +: DATA_W];
  assign mem_req_source_o = source_q;

  assign accept   = cpu_req_valid_i && req_ready_q;
  assign mem_fire = mem_req_valid_o && mem_req_ready_i;
  assign rd_issue = mem_fire && !write_q;
  // Stray responses (e.g. for reads abandoned by a reset) are dropped here.
  assign rsp_take = mem_rsp_valid_i && (outstanding_q != '0);
  assign rsp_done = rsp_valid_q && cpu_rsp_ready_i;

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_issue && !rsp_take) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!rd_issue && rsp_take) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  lane_index_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (LaneW)
  ) u_lane_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (rd_issue),
    .push_data_i (lane_sel),
    .pop_i       (rsp_take),
    .head_o      (fifo_head)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      write_q       <= 1'b0;
      mask_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      source_q      <= '0;
      rdata_q       <= '0;
      error_q       <= 1'b0;
      issued_q      <= '0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;

      if (rsp_take) begin
        rdata_q[fifo_head*DATA_W +: DATA_W] <= mem_rsp_data_i;
        if (mem_rsp_source_i != source_q) begin
          error_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            write_q     <= cpu_req_write_i;
            mask_q      <= cpu_req_mask_i;
            addr_q      <= cpu_req_addr_i;
            wdata_q     <= cpu_req_wdata_i;
            source_q    <= cpu_req_source_i;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            issued_q    <= '0;
            state_q     <= (|cpu_req_mask_i) ? StIssue : StRespond;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StIssue: begin
          if (mem_fire) begin
            issued_q <= issued_q | sel_onehot;
            if (last_issue) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (outstanding_q == '0) begin
            state_q <= StRespond;
          end
        end
        StRespond: begin
          // Response flag is raised one cycle after entry so all captured data
          // has settled into the output registers before it is presented.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_done) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cpu_req_ready_o  = req_ready_q;
  assign cpu_rsp_valid_o  = rsp_valid_q;
  assign cpu_rsp_write_o  = write_q;
  assign cpu_rsp_rdata_o  = rdata_q;
  assign cpu_rsp_source_o = source_q;
  assign cpu_rsp_error_o  = error_q;

endmodule
